// File: rtl/trig_pkg.sv
// Shared types for the multi-stage trigger sequencer.
package trig_pkg;

    typedef enum logic [1:0] {
        LEVEL  = 2'd0,
        RISE   = 2'd1,
        FALL   = 2'd2,
        CHANGE = 2'd3
    } trig_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } trig_state_e;

endpackage

// File: rtl/trig_match.sv
// Single-stage match evaluator: compares the masked probe against the stage
// value or the masked previous sample, depending on the mode.
module trig_match
    import trig_pkg::*;
#(
    parameter int PROBE_W = 8
) (
    input  logic [PROBE_W-1:0] probe,
    input  logic [PROBE_W-1:0] prev_probe,
    input  logic [PROBE_W-1:0] value,
    input  logic [PROBE_W-1:0] mask,
    input  trig_mode_e         mode,
    output logic               match
);

    logic [PROBE_W-1:0] m;
    logic [PROBE_W-1:0] p;

    always_comb begin
        m     = probe & mask;
        p     = prev_probe & mask;
        match = 1'b0;
        unique case (mode)
            LEVEL:  match = (m == (value & mask));
            RISE:   match = (p == '0) && (m != '0);
            FALL:   match = (p != '0) && (m == '0);
            CHANGE: match = (m != p);
            default: match = 1'b0;
        endcase
    end

endmodule

// File: rtl/trig_sequencer.sv
// Multi-stage trigger sequencer: walks NUM_STAGES ordered conditions on the
// probe bus and pulses trigger_hit when the last configured stage passes.
//
//   state | meaning
//   IDLE  | not armed, probe matches ignored
//   ARMED | evaluating stage cur_stage, counting occurrences
//   DONE  | sequence complete, triggered held until arm/disarm
module trig_sequencer
    import trig_pkg::*;
#(
    parameter int PROBE_W    = 8,
    parameter int NUM_STAGES = 4,
    parameter int COUNT_W    = 8,
    parameter int STG_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PROBE_W-1:0]            probe_data,
    input  logic                          arm,
    input  logic                          disarm,
    input  logic [NUM_STAGES*PROBE_W-1:0] cfg_value,
    input  logic [NUM_STAGES*PROBE_W-1:0] cfg_mask,
    input  logic [NUM_STAGES*2-1:0]       cfg_mode,
    input  logic [NUM_STAGES*COUNT_W-1:0] cfg_count,
    input  logic [STG_W-1:0]              cfg_last,
    output logic                          armed,
    output logic                          triggered,
    output logic                          trigger_hit,
    output logic [STG_W-1:0]              cur_stage,
    output logic [COUNT_W-1:0]            occ_count
);

    trig_state_e        state;
    logic [PROBE_W-1:0] prev_probe;

    logic [PROBE_W-1:0] stg_value;
    logic [PROBE_W-1:0] stg_mask;
    trig_mode_e         stg_mode;
    logic [COUNT_W-1:0] stg_count;
    logic [COUNT_W-1:0] eff_count;
    logic [STG_W-1:0]   eff_last;
    logic               occ_more;
    logic               stg_match;

    always_comb begin
        stg_value = '0;
        stg_mask  = '0;
        stg_mode  = LEVEL;
        stg_count = '0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            if (cur_stage == STG_W'(s)) begin
                stg_value = cfg_value[s*PROBE_W +: PROBE_W];
                stg_mask  = cfg_mask[s*PROBE_W +: PROBE_W];
                stg_mode  = trig_mode_e'(cfg_mode[s*2 +: 2]);
                stg_count = cfg_count[s*COUNT_W +: COUNT_W];
            end
        end
    end

    // Widened compares keep the clamp and the count test free of overflow.
    always_comb begin
        eff_count = (stg_count == '0) ? COUNT_W'(1) : stg_count;
        eff_last  = ({1'b0, cfg_last} > (STG_W+1)'(NUM_STAGES - 1))
                  ? STG_W'(NUM_STAGES - 1) : cfg_last;
        occ_more  = ({1'b0, occ_count} + (COUNT_W+1)'(1)) < {1'b0, eff_count};
    end

    trig_match #(.PROBE_W(PROBE_W)) u_match (
        .probe      (probe_data),
        .prev_probe (prev_probe),
        .value      (stg_value),
        .mask       (stg_mask),
        .mode       (stg_mode),
        .match      (stg_match)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prev_probe  <= '0;
            armed       <= 1'b0;
            triggered   <= 1'b0;
            trigger_hit <= 1'b0;
            cur_stage   <= '0;
            occ_count   <= '0;
        end else begin
            prev_probe  <= probe_data;
            trigger_hit <= 1'b0;
            if (disarm) begin
                state     <= IDLE;
                armed     <= 1'b0;
                triggered <= 1'b0;
                cur_stage <= '0;
                occ_count <= '0;
            end else if (arm) begin
                state     <= ARMED;
                armed     <= 1'b1;
                triggered <= 1'b0;
                cur_stage <= '0;
                occ_count <= '0;
            end else begin
                unique case (state)
                    ARMED: begin
                        if (stg_match) begin
                            if (occ_more) begin
                                occ_count <= occ_count + COUNT_W'(1);
                            end else if (cur_stage == eff_last) begin
                                state       <= DONE;
                                armed       <= 1'b0;
                                triggered   <= 1'b1;
                                trigger_hit <= 1'b1;
                                occ_count   <= '0;
                            end else begin
                                cur_stage <= cur_stage + STG_W'(1);
                                occ_count <= '0;
                            end
                        end
                    end
                    IDLE, DONE: begin
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_trig_sequencer.sv
// Directed bench for trig_sequencer: each stimulus cycle queues the expected
// post-edge outputs, and a monitor pops and compares them after every edge.
module tb_trig_sequencer;
    import trig_pkg::*;

    localparam int PW = 8;
    localparam int NS = 4;
    localparam int CW = 8;
    localparam int SW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [PW-1:0]    probe_data;
    logic             arm;
    logic             disarm;
    logic [NS*PW-1:0] cfg_value;
    logic [NS*PW-1:0] cfg_mask;
    logic [NS*2-1:0]  cfg_mode;
    logic [NS*CW-1:0] cfg_count;
    logic [SW-1:0]    cfg_last;
    logic             armed;
    logic             triggered;
    logic             trigger_hit;
    logic [SW-1:0]    cur_stage;
    logic [CW-1:0]    occ_count;

    always #5 clk = ~clk;

    trig_sequencer #(.PROBE_W(PW), .NUM_STAGES(NS), .COUNT_W(CW), .STG_W(SW)) dut (
        .clk         (clk),
        .rst         (rst),
        .probe_data  (probe_data),
        .arm         (arm),
        .disarm      (disarm),
        .cfg_value   (cfg_value),
        .cfg_mask    (cfg_mask),
        .cfg_mode    (cfg_mode),
        .cfg_count   (cfg_count),
        .cfg_last    (cfg_last),
        .armed       (armed),
        .triggered   (triggered),
        .trigger_hit (trigger_hit),
        .cur_stage   (cur_stage),
        .occ_count   (occ_count)
    );

    typedef struct {
        int   id;
        logic armed;
        logic triggered;
        logic hit;
        int   stage;
        int   occ;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_id = 0;

    task automatic chk(input string name, input int id, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, id, act, exp);
        end
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("armed",       e.id, int'(armed),       int'(e.armed));
            chk("triggered",   e.id, int'(triggered),   int'(e.triggered));
            chk("trigger_hit", e.id, int'(trigger_hit), int'(e.hit));
            chk("cur_stage",   e.id, int'(cur_stage),   e.stage);
            chk("occ_count",   e.id, int'(occ_count),   e.occ);
        end
    end

    // Drive one cycle of inputs and queue the outputs expected after the next edge.
    task automatic step(input logic [PW-1:0] p, input logic a, input logic d, input logic r,
                        input logic ea, input logic et, input logic eh, input int es, input int eo);
        exp_t e;
        @(negedge clk);
        probe_data = p;
        arm        = a;
        disarm     = d;
        rst        = r;
        e.id        = vec_id;
        e.armed     = ea;
        e.triggered = et;
        e.hit       = eh;
        e.stage     = es;
        e.occ       = eo;
        exp_q.push_back(e);
        vec_id++;
    endtask

    task automatic set_stage(input int s, input logic [PW-1:0] v, input logic [PW-1:0] m,
                             input trig_mode_e md, input logic [CW-1:0] c);
        cfg_value[s*PW +: PW] = v;
        cfg_mask[s*PW +: PW]  = m;
        cfg_mode[s*2 +: 2]    = md;
        cfg_count[s*CW +: CW] = c;
    endtask

    initial begin
        int last_req;
        rst        = 1'b1;
        arm        = 1'b0;
        disarm     = 1'b0;
        probe_data = '0;
        cfg_value  = '0;
        cfg_mask   = '0;
        cfg_mode   = '0;
        cfg_count  = '0;
        cfg_last   = '0;
        set_stage(0, 8'hA5, 8'hFF, LEVEL, 8'd1);

        // reset with toggling probe, then no arm
        step(8'h5A, 0, 0, 1,  0, 0, 0, 0, 0);
        step(8'hA5, 0, 0, 1,  0, 0, 0, 0, 0);
        step(8'hA5, 0, 0, 0,  0, 0, 0, 0, 0);
        step(8'hA5, 0, 0, 0,  0, 0, 0, 0, 0);

        // single LEVEL stage
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h00, 0, 0, 0,  1, 0, 0, 0, 0);
        step(8'hA5, 0, 0, 0,  0, 1, 1, 0, 0);
        step(8'hA5, 0, 0, 0,  0, 1, 0, 0, 0);
        step(8'hA5, 0, 0, 0,  0, 1, 0, 0, 0);
        step(8'h00, 0, 1, 0,  0, 0, 0, 0, 0);

        // two stages: RISE then FALL x3
        set_stage(0, 8'h00, 8'h0F, RISE, 8'd1);
        set_stage(1, 8'h00, 8'h0F, FALL, 8'd3);
        cfg_last = 2'd1;
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h01, 0, 0, 0,  1, 0, 0, 1, 0);
        step(8'h00, 0, 0, 0,  1, 0, 0, 1, 1);
        step(8'h01, 0, 0, 0,  1, 0, 0, 1, 1);
        step(8'h00, 0, 0, 0,  1, 0, 0, 1, 2);
        step(8'h01, 0, 0, 0,  1, 0, 0, 1, 2);
        step(8'h00, 0, 0, 0,  0, 1, 1, 1, 0);
        step(8'h00, 0, 0, 0,  0, 1, 0, 1, 0);

        // control precedence: re-arm from DONE, re-arm at stage 1 discards match,
        // arm+disarm goes idle, rst mid-sequence
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h01, 0, 0, 0,  1, 0, 0, 1, 0);
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h00, 1, 1, 0,  0, 0, 0, 0, 0);
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h01, 0, 0, 0,  1, 0, 0, 1, 0);
        step(8'h00, 0, 0, 0,  1, 0, 0, 1, 1);
        step(8'h01, 0, 0, 1,  0, 0, 0, 0, 0);
        step(8'h01, 0, 0, 0,  0, 0, 0, 0, 0);

        // CHANGE on upper nibble
        set_stage(0, 8'h00, 8'hF0, CHANGE, 8'd1);
        cfg_last = 2'd0;
        step(8'h1F, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h10, 0, 0, 0,  1, 0, 0, 0, 0);
        step(8'h20, 0, 0, 0,  0, 1, 1, 0, 0);
        step(8'h00, 0, 1, 0,  0, 0, 0, 0, 0);

        // count 0 acts as 1
        set_stage(0, 8'h33, 8'hFF, LEVEL, 8'd0);
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h33, 0, 0, 0,  0, 1, 1, 0, 0);
        step(8'h00, 0, 1, 0,  0, 0, 0, 0, 0);

        // all four modes, last requested as 7 (port keeps low bits: stage 3)
        set_stage(0, 8'h05, 8'h0F, LEVEL,  8'd1);
        set_stage(1, 8'h00, 8'h80, RISE,   8'd1);
        set_stage(2, 8'h00, 8'h80, FALL,   8'd1);
        set_stage(3, 8'h00, 8'h01, CHANGE, 8'd2);
        last_req = 7;
        cfg_last = last_req[SW-1:0];
        step(8'h00, 1, 0, 0,  1, 0, 0, 0, 0);
        step(8'h05, 0, 0, 0,  1, 0, 0, 1, 0);
        step(8'h85, 0, 0, 0,  1, 0, 0, 2, 0);
        step(8'h05, 0, 0, 0,  1, 0, 0, 3, 0);
        step(8'h04, 0, 0, 0,  1, 0, 0, 3, 1);
        step(8'h04, 0, 0, 0,  1, 0, 0, 3, 1);
        step(8'h05, 0, 0, 0,  0, 1, 1, 3, 0);
        step(8'h05, 0, 0, 0,  0, 1, 0, 3, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", vec_id, exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
